tracker_sequencer: RTL

Pattern sequencer that drives the `tracker` voice. It holds a small pattern RAM of rows, each a `note_tp` plus a 4-bit speed. It steps through the rows at a programmable tempo and presents the current row's `note`/`speed` to `tracker`. It also handles start/stop, end-of-pattern markers and looping. It sits between host/test control and the `tracker` datapath.

---
 rtl/tracker_sequencer_pkg.sv | 40 ++++
 rtl/tracker_sequencer_row_timer.sv | 42 ++++
 rtl/tracker_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tracker_sequencer_pkg.sv
// Shared types and constants for the tracker voice and its pattern sequencer.
// Defining TRACKER_SEQ_SWING_EN adds the swing feature (longer even rows).
package tracker_sequencer_pkg;

  localparam int SPEED_W = 4;
  localparam int LEN_W   = 9;

  localparam logic [SPEED_W-1:0] SEQ_END_SPEED = '0;

  localparam logic [1:0] INSTR_SIN    = 2'd0;
  localparam logic [1:0] INSTR_SQUARE = 2'd1;
  localparam logic [1:0] INSTR_SAW    = 2'd2;
  localparam logic [1:0] INSTR_RAND   = 2'd3;

  typedef struct packed {
    logic [1:0] instrument;
    logic [7:0] pitch;
  } note_tp;

  typedef struct packed {
    note_tp             note;
    logic [SPEED_W-1:0] speed;
  } row_t;

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } seq_state_e;

  // Row duration: tempo 0 counts as 1; swing stretches even rows only.
  function automatic logic [LEN_W-1:0] row_length(input logic [7:0] tempo,
                                                  input logic [3:0] swing,
                                                  input logic       even_row);
    logic [LEN_W-1:0] len;
    len = (tempo == 8'd0) ? LEN_W'(1) : {1'b0, tempo};
    if (even_row) len = len + {5'd0, swing};
    return len;
  endfunction

endpackage

// File: rtl/tracker_sequencer_row_timer.sv
// Loadable down-counter that times how long one pattern row is presented.
// A load of length L raises expire in the L-th cycle after the load edge.
module row_timer
  import tracker_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] length,
  output logic             expire
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = length - LEN_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - LEN_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/tracker_sequencer.sv
// Pattern sequencer feeding the tracker voice: row RAM, tempo stepping, end/loop.
// Build with TRACKER_SEQ_SWING_EN defined to add the swing input.
module tracker_sequencer
  import tracker_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  note_tp             wr_note,
  input  logic [SPEED_W-1:0] wr_speed,
  input  logic               play,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [7:0]         tempo,
`ifdef TRACKER_SEQ_SWING_EN
  input  logic [3:0]         swing,
`endif
  output note_tp             note,
  output logic [SPEED_W-1:0] speed,
  output logic [ADDR_W-1:0]  row,
  output logic               busy,
  output logic               row_strobe,
  output logic               done
);

  logic [3:0] swing_eff;
`ifdef TRACKER_SEQ_SWING_EN
  assign swing_eff = swing;
`else
  assign swing_eff = 4'd0;
`endif

  row_t mem [DEPTH];

  // NOTE: the pattern RAM has no reset; a plain clocked write keeps it a RAM, not a flop bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_note, wr_speed};
  end

  seq_state_e         state_q, state_d;
  note_tp             note_q, note_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]  next_idx, load_idx;
  row_t               row0_rd, next_rd, load_row;
  logic               do_load, end_hit, expire;
  logic [LEN_W-1:0]   tmr_len;

  assign next_idx = ADDR_W'(row_q + 1'b1);

  // A write landing on the row being fetched is forwarded so the fetch sees new data.
  assign row0_rd = (wr_en && wr_addr == '0)       ? {wr_note, wr_speed} : mem[0];
  assign next_rd = (wr_en && wr_addr == next_idx) ? {wr_note, wr_speed} : mem[next_idx];

  // A silent row 0 (speed 0) is itself an end marker, so it loops or ends each pass.
  assign end_hit = (row_q == ADDR_W'(DEPTH - 1)) || (next_rd.speed == SEQ_END_SPEED) ||
                   (speed_q == SEQ_END_SPEED);

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    speed_d  = speed_q;
    row_d    = row_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    do_load  = 1'b0;
    load_idx = '0;
    load_row = row0_rd;

    if (stop) begin
      state_d = ST_IDLE;
      speed_d = SEQ_END_SPEED;
      row_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          speed_d = SEQ_END_SPEED;
          if (play) begin
            if (row0_rd.speed == SEQ_END_SPEED && !loop_en) begin
              done_d = 1'b1;
              row_d  = '0;
            end else begin
              do_load = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (expire) begin
            if (end_hit) begin
              if (loop_en) begin
                do_load = 1'b1;
              end else begin
                state_d = ST_IDLE;
                speed_d = SEQ_END_SPEED;
                row_d   = '0;
                done_d  = 1'b1;
              end
            end else begin
              do_load  = 1'b1;
              load_idx = next_idx;
              load_row = next_rd;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_load) begin
      state_d  = ST_PLAY;
      row_d    = load_idx;
      note_d   = load_row.note;
      speed_d  = load_row.speed;
      strobe_d = 1'b1;
    end

    busy_d = (state_d == ST_PLAY);
  end

  // Tempo and swing are captured only here, when the timer is loaded.
  assign tmr_len = row_length(tempo, swing_eff, ~load_idx[0]);

  row_timer u_row_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (do_load),
    .length (tmr_len),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      note_q   <= '0;
      speed_q  <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      speed_q  <= speed_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign note       = note_q;
  assign speed      = speed_q;
  assign row        = row_q;
  assign busy       = busy_q;
  assign row_strobe = strobe_q;
  assign done       = done_q;

endmodule
